// File: rtl/display_scan_ctrl.sv
// Multiplex-scan controller for a 4-digit 7-segment display, with frame-synchronous double buffering.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int PRESCALE    = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] num3,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  output logic [1:0] digit,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0,
  output logic [3:0] an_n,
  output logic       pending,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(PRESCALE - DEAD_CYCLES);

  typedef enum logic {SHOW, DEAD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      stage_q, stage_d;
  logic [15:0]      disp_q, disp_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic [3:0]       lit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DEAD;
      cnt_q     <= SHOW_END;
      digit_q   <= 2'd3;
      stage_q   <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      digit_q   <= digit_d;
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    digit_d   = digit_q;
    stage_d   = stage_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
      // Frame boundary: commit uses the staging contents from before this edge.
      if (digit_q == 2'd3) begin
        tick_d = 1'b1;
        if (pending_q) begin
          disp_d    = stage_q;
          pending_d = 1'b0;
        end
      end
    end
    if (load) begin
      stage_d   = {num3, num2, num1, num0};
      pending_d = 1'b1;
    end
    state_d = (cnt_d < SHOW_END) ? SHOW : DEAD;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] blank;
`endif

  always_comb begin
    lit = 4'b0001 << digit_q;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked only if it and every digit to its left are zero; digit 0 never blanks.
    blank    = 4'b0000;
    blank[3] = (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
    lit      = lit & ~blank;
`endif
    an_n = (state_q == SHOW) ? ~lit : 4'hF;
  end

  assign digit      = digit_q;
  assign disp3      = disp_q[15:12];
  assign disp2      = disp_q[11:8];
  assign disp1      = disp_q[7:4];
  assign disp0      = disp_q[3:0];
  assign pending    = pending_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed, table-driven bench for display_scan_ctrl with PRESCALE=8, DEAD_CYCLES=2.
// Honours LEADING_ZERO_BLANK_EN when the same macro is defined for the bench.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [3:0] num3 = '0, num2 = '0, num1 = '0, num0 = '0;
  logic [1:0] digit;
  logic [3:0] disp3, disp2, disp1, disp0;
  logic [3:0] an_n;
  logic       pending, frame_tick;
  logic [15:0] disp_all;

  int checks = 0;
  int failures = 0;

  assign disp_all = {disp3, disp2, disp1, disp0};

  always #5 clk = ~clk;

  display_scan_ctrl #(.PRESCALE(8), .DEAD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load),
    .num3(num3), .num2(num2), .num1(num1), .num0(num0),
    .digit(digit), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
    .an_n(an_n), .pending(pending), .frame_tick(frame_tick)
  );

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] nums;
    logic [3:0]  an;
    logic [1:0]  dig;
    logic        tick;
    logic        pend;
    logic [15:0] disp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected anode pattern: blanking only changes it when the feature is built in.
  function automatic logic [3:0] exp_an(input logic [3:0] an, input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    logic b3, b2, b1;
    b3 = (d[15:12] == 4'd0);
    b2 = b3 && (d[11:8] == 4'd0);
    b1 = b2 && (d[7:4] == 4'd0);
    return an | {b3, b2, b1, 1'b0};
`else
    return an;
`endif
  endfunction

  task automatic add(input int c, input logic ld, input logic [15:0] nums, input logic [3:0] an,
                     input logic [1:0] dig, input logic tick, input logic pend, input logic [15:0] disp);
    vec_t v;
    v.cyc = c; v.ld = ld; v.nums = nums; v.an = an; v.dig = dig;
    v.tick = tick; v.pend = pend; v.disp = disp;
    tbl.push_back(v);
  endtask

  task automatic commit(input logic [15:0] v);
    int n;
    load = 1'b1;
    {num3, num2, num1, num0} = v;
    step();
    load = 1'b0;
    chk("commit_pending", pending, 1'b1);
    n = 0;
    while (!frame_tick && n < 40) begin
      step();
      n++;
    end
    chk("commit_tick", frame_tick, 1'b1);
    chk("commit_disp", disp_all, v);
  endtask

  task automatic frame_lit(input string name, input logic [3:0] exp);
    logic [3:0] lit;
    lit = 4'b0000;
    repeat (32) begin
      step();
      lit = lit | ~an_n;
    end
    chk(name, lit, exp);
  endtask

  initial begin
    int idx;
    int ticks;
    int c;

    // cycle, load, nums, an_n, digit, tick, pending, disp
    add(0,   0, 16'h0,    4'hF, 2'd3, 0, 0, 16'h0000);
    add(1,   0, 16'h0,    4'hF, 2'd3, 0, 0, 16'h0000);
    add(2,   0, 16'h0,    4'hE, 2'd0, 1, 0, 16'h0000);
    add(3,   0, 16'h0,    4'hE, 2'd0, 0, 0, 16'h0000);
    add(7,   0, 16'h0,    4'hE, 2'd0, 0, 0, 16'h0000);
    add(8,   0, 16'h0,    4'hF, 2'd0, 0, 0, 16'h0000);
    add(9,   0, 16'h0,    4'hF, 2'd0, 0, 0, 16'h0000);
    add(10,  0, 16'h0,    4'hD, 2'd1, 0, 0, 16'h0000);
    add(12,  1, 16'h1234, 4'hD, 2'd1, 0, 0, 16'h0000);
    add(13,  0, 16'h0,    4'hD, 2'd1, 0, 1, 16'h0000);
    add(16,  0, 16'h0,    4'hF, 2'd1, 0, 1, 16'h0000);
    add(18,  0, 16'h0,    4'hB, 2'd2, 0, 1, 16'h0000);
    add(24,  0, 16'h0,    4'hF, 2'd2, 0, 1, 16'h0000);
    add(26,  0, 16'h0,    4'h7, 2'd3, 0, 1, 16'h0000);
    add(31,  0, 16'h0,    4'h7, 2'd3, 0, 1, 16'h0000);
    add(32,  0, 16'h0,    4'hF, 2'd3, 0, 1, 16'h0000);
    add(33,  0, 16'h0,    4'hF, 2'd3, 0, 1, 16'h0000);
    add(34,  0, 16'h0,    4'hE, 2'd0, 1, 0, 16'h1234);
    add(35,  0, 16'h0,    4'hE, 2'd0, 0, 0, 16'h1234);
    add(40,  1, 16'h5555, 4'hF, 2'd0, 0, 0, 16'h1234);
    add(41,  0, 16'h0,    4'hF, 2'd0, 0, 1, 16'h1234);
    add(50,  1, 16'h9876, 4'hB, 2'd2, 0, 1, 16'h1234);
    add(51,  0, 16'h0,    4'hB, 2'd2, 0, 1, 16'h1234);
    add(65,  0, 16'h0,    4'hF, 2'd3, 0, 1, 16'h1234);
    add(66,  0, 16'h0,    4'hE, 2'd0, 1, 0, 16'h9876);
    add(67,  0, 16'h0,    4'hE, 2'd0, 0, 0, 16'h9876);
    add(97,  1, 16'hABCD, 4'hF, 2'd3, 0, 0, 16'h9876);
    add(98,  0, 16'h0,    4'hE, 2'd0, 1, 1, 16'h9876);
    add(99,  0, 16'h0,    4'hE, 2'd0, 0, 1, 16'h9876);
    add(129, 0, 16'h0,    4'hF, 2'd3, 0, 1, 16'h9876);
    add(130, 0, 16'h0,    4'hE, 2'd0, 1, 0, 16'hABCD);
    add(131, 0, 16'h0,    4'hE, 2'd0, 0, 0, 16'hABCD);

    step();
    chk("reset_an_n", an_n, 4'hF);
    chk("reset_digit", digit, 2'd3);
    chk("reset_pending", pending, 1'b0);
    reset = 1'b0;

    idx = 0;
    ticks = 0;
    for (int cy = 0; cy <= 131; cy++) begin
      if (cy > 0) step();
      load = 1'b0;
      chk("an_single", ($countones(~an_n) <= 1), 1'b1);
      if (frame_tick) ticks++;
      while (idx < tbl.size() && tbl[idx].cyc == cy) begin
        chk($sformatf("c%0d_an_n", cy), an_n, exp_an(tbl[idx].an, tbl[idx].disp));
        chk($sformatf("c%0d_digit", cy), digit, tbl[idx].dig);
        chk($sformatf("c%0d_tick", cy), frame_tick, tbl[idx].tick);
        chk($sformatf("c%0d_pending", cy), pending, tbl[idx].pend);
        chk($sformatf("c%0d_disp", cy), disp_all, tbl[idx].disp);
        if (tbl[idx].ld) begin
          load = 1'b1;
          {num3, num2, num1, num0} = tbl[idx].nums;
        end
        idx++;
      end
    end
    chk("tick_count", ticks, 5);

    // Asynchronous reset in the middle of digit 2's lit window
    load = 1'b1;
    {num3, num2, num1, num0} = 16'h1234;
    c = 131;
    while (c < 180) begin
      step();
      load = 1'b0;
      c++;
      if (c == 162) begin
        chk("r_commit_disp", disp_all, 16'h1234);
        chk("r_commit_tick", frame_tick, 1'b1);
      end
    end
    chk("pre_reset_an_n", an_n, 4'hB);
    chk("pre_reset_digit", digit, 2'd2);
    #3 reset = 1'b1;
    #1;
    chk("async_an_n", an_n, 4'hF);
    chk("async_disp", disp_all, 16'h0000);
    chk("async_digit", digit, 2'd3);
    chk("async_pending", pending, 1'b0);
    step();
    reset = 1'b0;
    chk("rel_c0_an_n", an_n, 4'hF);
    step();
    chk("rel_c1_an_n", an_n, 4'hF);
    step();
    chk("rel_c2_an_n", an_n, 4'hE);
    chk("rel_c2_tick", frame_tick, 1'b1);
    repeat (8) step();
    chk("rel_c10_an_n", an_n, exp_an(4'hD, 16'h0000));
    chk("rel_c10_digit", digit, 2'd1);

    // Leading-zero blanking patterns
    commit(16'h0007);
`ifdef LEADING_ZERO_BLANK_EN
    frame_lit("lzb_0007", 4'b0001);
`else
    frame_lit("lzb_0007", 4'b1111);
`endif
    commit(16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
    frame_lit("lzb_0000", 4'b0001);
`else
    frame_lit("lzb_0000", 4'b1111);
`endif
    commit(16'h0401);
`ifdef LEADING_ZERO_BLANK_EN
    frame_lit("lzb_0401", 4'b0111);
`else
    frame_lit("lzb_0401", 4'b1111);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
